// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each op takes a fixed
// WIDTH+1 cycles from the start edge to the done pulse, divide-by-zero included.
// MTHI/MTLO writes are accepted only while the unit is idle.
// Optional build macro MDU_ABORT_EN adds an 'abort' input that flushes an operation in flight.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_val,
`ifdef MDU_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   // Two's-complement negate when 'neg' is set (single-width result).
   function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Two's-complement negate when 'neg' is set (double-width product).
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

   state_e             state_q;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               is_div_q;   // op[1] latched at start
   logic               neg_q;      // negate product / quotient
   logic               neg_r_q;    // negate remainder (dividend was negative)
   logic               div0_q;     // divisor was zero
   // Shared accumulator: multiply -> {partial hi, multiplier/low product};
   // divide -> {remainder, dividend shifting into quotient}.
   logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
   logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude

   // Start-time operand preparation
   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // Per-iteration next values
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_borrow;
   logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;

   // Sign-corrected final results
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

   logic               abort_hit;

`ifdef MDU_ABORT_EN
   assign abort_hit = abort && (state_q != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & src_a[WIDTH-1];
   assign b_neg     = signed_op & src_b[WIDTH-1];
   assign a_mag     = neg_w(a_neg, src_a);
   assign b_mag     = neg_w(b_neg, src_b);

   // One iteration of shift-add multiply and restoring divide; op selects which is kept.
   always_comb begin
      mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff   = div_shift - {1'b0, opb_q};
      div_borrow = div_diff[WIDTH];
      if (is_div_q) begin
         acc_hi_d = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_borrow};
      end else begin
         acc_hi_d = mul_sum[WIDTH:1];
         acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Final sign correction. Dividing by zero leaves the dividend magnitude in the
   // remainder, so the remainder fix restores the original src_a; quotient is forced to all-ones.
   always_comb begin
      prod_fix = neg_2w(neg_q, {acc_hi_q, acc_lo_q});
      quo_fix  = div0_q ? {WIDTH{1'b1}} : neg_w(neg_q, acc_lo_q);
      rem_fix  = neg_w(neg_r_q, acc_hi_q);
      fix_hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
   end

   // Control FSM with registered busy/done and HI/LO updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort_hit) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     is_div_q <= op[1];
                     neg_q    <= a_neg ^ b_neg;
                     neg_r_q  <= a_neg;
                     div0_q   <= op[1] && (src_b == '0);
                     acc_hi_q <= '0;
                     acc_lo_q <= op[1] ? a_mag : b_mag;
                     opb_q    <= op[1] ? b_mag : a_mag;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= S_CALC;
                  end else begin
                     if (hi_we) hi_q <= wr_val;
                     if (lo_we) lo_q <= wr_val;
                  end
               end
               S_CALC: begin
                  acc_hi_q <= acc_hi_d;
                  acc_lo_q <= acc_lo_d;
                  cnt_q    <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
               end
               S_FIX: begin
                  hi_q    <= fix_hi_d;
                  lo_q    <= fix_lo_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written busy/reset/abort sequences.
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  src_a, src_b;
   logic          hi_we, lo_we;
   logic [W-1:0]  wr_val;
   logic          busy, done;
   logic [W-1:0]  hi, lo;
`ifdef MDU_ABORT_EN
   logic          abort;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wr_val (wr_val),
`ifdef MDU_ABORT_EN
      .abort  (abort),
`endif
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the MIPS definitions.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eh, output logic [W-1:0] el);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      eh = '0;
      el = '0;
      case (o)
         2'b00: begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
         end
         2'b01: begin
            p  = {32'h0, a} * {32'h0, b};
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (b == '0) begin
               el = '1;
               eh = a;
            end else if (o == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               el = sq[31:0];
               eh = sr[31:0];
            end else begin
               el = a / b;
               eh = a % b;
            end
         end
      endcase
   endfunction

   // Issue one op, scramble operands afterwards, wait (bounded) for done.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl,
                        output int lat, output int busy_err);
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      lat = -1; busy_err = 0; rh = '0; rl = '0;
      for (int k = 1; k <= LAT + 20; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k; rh = hi; rl = lo;
            if (busy) busy_err++;
            break;
         end
         if (!busy) busy_err++;
      end
   endtask

   task automatic run_checked(input string name, input logic [1:0] o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      logic [W-1:0] rh, rl;
      int lat, berr;
      do_op(o, a, b, rh, rl, lat, berr);
      chk({name, " latency"}, 32'(lat), 32'(LAT));
      chk({name, " busy"}, 32'(berr), 32'd0);
      chk({name, " hi"}, rh, eh);
      chk({name, " lo"}, rl, el);
      @(negedge clk);
      chk({name, " done width"}, 32'(done), 32'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'h8000_0000;
         2: return '1;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic write_hilo(input logic h, input logic l, input logic [W-1:0] v);
      @(negedge clk);
      hi_we = h; lo_we = l; wr_val = v;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      logic [W-1:0] eh, el;
      logic [1:0]   o;
      logic [W-1:0] a, b;
      int           lat, cnt;

      vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
      vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[9] = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

      rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wr_val = '0;
`ifdef MDU_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      rst_n = 1'b1;

      // MTHI and MTLO together
      write_hilo(1'b1, 1'b1, 32'h0000_0077);
      chk("mthi+mtlo hi", hi, 32'h0000_0077);
      chk("mthi+mtlo lo", lo, 32'h0000_0077);
      chk("mthi+mtlo done", 32'(done), 32'd0);

      // Directed vector table
      for (int i = 0; i < 10; i++)
         run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].exp_hi, vecs[i].exp_lo);

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         model(o, a, b, eh, el);
         run_checked($sformatf("rnd%0d op%0d a=%08h b=%08h", i, o, a, b), o, a, b, eh, el);
      end

      // MTHI / MTLO in IDLE
      write_hilo(1'b1, 1'b0, 32'h0000_AAAA);
      write_hilo(1'b0, 1'b1, 32'h0000_5555);
      chk("mthi", hi, 32'h0000_AAAA);
      chk("mtlo", lo, 32'h0000_5555);

      // MULTU 2x3 with a same-cycle hi_we, then a second start + hi_we at cycle 5
      @(negedge clk);
      op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1; hi_we = 1'b1; wr_val = 32'h0000_FFFF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      chk("start beats hi_we", hi, 32'h0000_AAAA);
      repeat (5) @(negedge clk);
      op = 2'b00; src_a = 32'd7; src_b = 32'd7; start = 1'b1; hi_we = 1'b1; wr_val = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      chk("busy hi_we ignored", hi, 32'h0000_AAAA);
      chk("busy during op", 32'(busy), 32'd1);
      lat = -1;
      for (int k = 7; k <= LAT + 20; k++) begin
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
      chk("second start latency", 32'(lat), 32'(LAT));
      chk("second start hi", hi, 32'h0);
      chk("second start lo", lo, 32'd6);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy || done) cnt++;
      end
      chk("no queued start", 32'(cnt), 32'd0);

`ifdef MDU_ABORT_EN
      // Abort mid-operation keeps HI/LO and suppresses done
      write_hilo(1'b1, 1'b0, 32'h0000_1111);
      write_hilo(1'b0, 1'b1, 32'h0000_2222);
      @(negedge clk);
      op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort hi", hi, 32'h0000_1111);
      chk("abort lo", lo, 32'h0000_2222);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("abort no done", 32'(cnt), 32'd0);
`endif

      // Asynchronous reset mid-operation
      write_hilo(1'b1, 1'b1, 32'h0000_3C3C);
      @(negedge clk);
      op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy before reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async reset hi", hi, 32'h0);
      chk("async reset lo", lo, 32'h0);
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      chk("reset no done", 32'(cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit. It sits directly downstream of the register file read ports.
- Operands come from rd_data1/rd_data2. The unit computes MIPS MULT/MULTU/DIV/DIVU into the architectural HI/LO registers.
- HI/LO are read back by the datapath (MFHI/MFLO), which then feeds wr_data of the register file.
- MTHI/MTLO writes are also handled here.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  input  WIDTH  multiplicand/dividend (rd_data1).
- src_b  input  WIDTH  multiplier/divisor (rd_data2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wr_val  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV while high.
- done  output  1  one-cycle pulse; HI/LO updated this cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal accumulators cleared.
  - Takes effect immediately, including mid-operation. A partial result is discarded; no done.
- States:
  - IDLE: start=1 at edge N latches op, the operand magnitudes (signed ops take the absolute value) and the result sign flags. Counter=0; go to CALC; busy=1 from N+1.
  - CALC: one iteration per cycle, WIDTH cycles (edges N+1..N+WIDTH). After the final iteration, go to FIX.
  - FIX: at edge N+WIDTH+1, apply sign correction; write hi/lo; done=1 for exactly that cycle; busy=0; go to IDLE.
- Latency: fixed WIDTH+1 cycles from the start edge to done (33 for the default). This applies to all ops, including divide-by-zero.
- Multiply:
  - Shift-add over unsigned magnitudes; 2*WIDTH-bit product.
  - MULT negates the product if the operand signs differ.
  - {hi,lo} = product.
- Divide:
  - Restoring division, one quotient bit per cycle. lo=quotient, hi=remainder.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (src_b=0 at start):
  - Full latency still runs.
  - In FIX: lo=all-ones, hi=src_a as latched (unsigned and signed alike).
- Busy rules:
  - start while busy=1 is ignored, with no queueing.
  - hi_we/lo_we while busy=1 are ignored; HI/LO keep their previous value until FIX.
- MTHI/MTLO:
  - In IDLE with start=0, hi_we/lo_we load wr_val at the edge; both may be asserted together.
  - start and hi_we/lo_we in the same IDLE cycle: start wins; the writes are dropped.
  - done=0 for MTHI/MTLO writes.
- Operand inputs are only sampled at the start edge. Later changes have no effect.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in CALC or FIX returns to IDLE at the next edge. HI/LO are unchanged, there is no done pulse, and busy=0 from that edge.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start proceeds.
  - Used to flush on exception.
- Not defined: port absent; an operation always completes.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1..32 after start.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Division cases:
  - DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 -> lo=14, hi=2.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> after 33 cycles: lo=0xFFFFFFFF, hi=0x1234, one done pulse.
- MTHI 0xAAAA then MTLO 0x5555 in IDLE -> hi=0xAAAA, lo=0x5555.
  - Then start MULTU 2x3, with a second start and hi_we=1 at cycle 5 -> both ignored; hi=0, lo=6 at done.
- Start MULT 5x5, drive rst_n=0 at cycle 10 -> hi=lo=0 and busy=0 immediately; no done.
  - With MDU_ABORT_EN: abort at cycle 10 -> busy=0 next edge; hi/lo keep their prior values; no done.
